// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared types and constants for the 13-tap median window
package median_pkg;

    localparam int MEDIAN_N = 13;

    typedef logic [31:0] data_t;

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_STEP = 2'd1,
        S_OUT  = 2'd2
    } median_state_t;

endpackage

// File: rtl/median_window_13.sv
// rtl/median_window_13.sv - sliding 13-sample window with stride and flush for a median network
module median_window_13
    import median_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STRIDE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] data_0,
    output logic [WIDTH-1:0] data_1,
    output logic [WIDTH-1:0] data_2,
    output logic [WIDTH-1:0] data_3,
    output logic [WIDTH-1:0] data_4,
    output logic [WIDTH-1:0] data_5,
    output logic [WIDTH-1:0] data_6,
    output logic [WIDTH-1:0] data_7,
    output logic [WIDTH-1:0] data_8,
    output logic [WIDTH-1:0] data_9,
    output logic [WIDTH-1:0] data_10,
    output logic [WIDTH-1:0] data_11,
    output logic [WIDTH-1:0] data_12,
    output logic             out_valid,
    input  logic             out_ready
);

    generate
        if (STRIDE < 1 || STRIDE > MEDIAN_N) begin : g_bad_stride
            $error("median_window_13: STRIDE must be in 1..13");
        end
        if (WIDTH < 1 || WIDTH > $bits(data_t)) begin : g_bad_width
            $error("median_window_13: WIDTH must be in 1..32");
        end
    endgenerate

    median_state_t r_state;
    median_state_t w_state_nxt;
    logic [3:0]    r_fill;
    logic [3:0]    w_fill_nxt;
    logic [3:0]    r_stride;
    logic [3:0]    w_stride_nxt;
    data_t         r_win [MEDIAN_N];
    logic          w_accept;
    logic [3:0]    w_stride_inc;

    assign out_valid    = (r_state == S_OUT);
    assign in_ready     = rst_n && (!out_valid || out_ready) && !flush;
    assign w_accept     = in_valid && in_ready;
    assign w_stride_inc = r_stride + 4'd1;

    always_comb begin
        w_state_nxt  = r_state;
        w_fill_nxt   = r_fill;
        w_stride_nxt = r_stride;
        if (w_accept && r_fill != 4'(MEDIAN_N)) begin
            w_fill_nxt = r_fill + 4'd1;
        end
        case (r_state)
            S_FILL: begin
                if (w_accept && r_fill == 4'(MEDIAN_N - 1)) begin
                    w_state_nxt  = S_OUT;
                    w_stride_nxt = 4'd0;
                end
            end
            S_STEP: begin
                if (w_accept) begin
                    if (w_stride_inc == 4'(STRIDE)) begin
                        w_state_nxt  = S_OUT;
                        w_stride_nxt = 4'd0;
                    end else begin
                        w_stride_nxt = w_stride_inc;
                    end
                end
            end
            S_OUT: begin
                // an accept here is only possible with out_ready=1 and is the first stride sample
                if (w_accept) begin
                    if (STRIDE == 1) begin
                        w_stride_nxt = 4'd0;
                    end else begin
                        w_state_nxt  = S_STEP;
                        w_stride_nxt = 4'd1;
                    end
                end else if (out_ready) begin
                    w_state_nxt  = S_STEP;
                    w_stride_nxt = 4'd0;
                end
            end
            default: begin
                w_state_nxt  = S_FILL;
                w_stride_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_state  <= S_FILL;
            r_fill   <= 4'd0;
            r_stride <= 4'd0;
            for (int k = 0; k < MEDIAN_N; k++) begin
                r_win[k] <= '0;
            end
        end else begin
            r_state  <= w_state_nxt;
            r_fill   <= w_fill_nxt;
            r_stride <= w_stride_nxt;
            if (w_accept) begin
                for (int k = 0; k < MEDIAN_N - 1; k++) begin
                    r_win[k] <= r_win[k+1];
                end
                r_win[MEDIAN_N-1] <= data_t'(in_data);
            end
        end
    end

    assign data_0  = r_win[0][WIDTH-1:0];
    assign data_1  = r_win[1][WIDTH-1:0];
    assign data_2  = r_win[2][WIDTH-1:0];
    assign data_3  = r_win[3][WIDTH-1:0];
    assign data_4  = r_win[4][WIDTH-1:0];
    assign data_5  = r_win[5][WIDTH-1:0];
    assign data_6  = r_win[6][WIDTH-1:0];
    assign data_7  = r_win[7][WIDTH-1:0];
    assign data_8  = r_win[8][WIDTH-1:0];
    assign data_9  = r_win[9][WIDTH-1:0];
    assign data_10 = r_win[10][WIDTH-1:0];
    assign data_11 = r_win[11][WIDTH-1:0];
    assign data_12 = r_win[12][WIDTH-1:0];

endmodule

// File: tb/tb_median_window_13.sv
// tb/tb_median_window_13.sv - directed bench for median_window_13 at STRIDE=1 and STRIDE=4
module tb_median_window_13;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a_in_data;
    logic        a_in_valid;
    logic        a_in_ready;
    logic        a_flush;
    logic [31:0] a_d [13];
    logic        a_out_valid;
    logic        a_out_ready;
    logic [31:0] b_in_data;
    logic        b_in_valid;
    logic        b_in_ready;
    logic        b_flush;
    logic [31:0] b_d [13];
    logic        b_out_valid;
    logic        b_out_ready;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    median_window_13 #(.WIDTH(32), .STRIDE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .flush(a_flush),
        .data_0(a_d[0]), .data_1(a_d[1]), .data_2(a_d[2]), .data_3(a_d[3]),
        .data_4(a_d[4]), .data_5(a_d[5]), .data_6(a_d[6]), .data_7(a_d[7]),
        .data_8(a_d[8]), .data_9(a_d[9]), .data_10(a_d[10]), .data_11(a_d[11]),
        .data_12(a_d[12]), .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    median_window_13 #(.WIDTH(32), .STRIDE(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .flush(b_flush),
        .data_0(b_d[0]), .data_1(b_d[1]), .data_2(b_d[2]), .data_3(b_d[3]),
        .data_4(b_d[4]), .data_5(b_d[5]), .data_6(b_d[6]), .data_7(b_d[7]),
        .data_8(b_d[8]), .data_9(b_d[9]), .data_10(b_d[10]), .data_11(b_d[11]),
        .data_12(b_d[12]), .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    task automatic push_a(input logic [31:0] v);
        a_in_data  = v;
        a_in_valid = 1'b1;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_total++;
        if (a_in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", a_in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", a_out_valid);
        else n_pass++;
        for (int k = 0; k < 13; k++) begin
            n_total++;
            if (a_d[k] !== 32'd0) $display("FAIL reset_data_%0d got=%0d exp=0", k, a_d[k]);
            else n_pass++;
        end
        rst_n = 1'b1;
        #1;
        n_total++;
        if (a_in_ready !== 1'b1) $display("FAIL post_reset_in_ready got=%b exp=1", a_in_ready);
        else n_pass++;
    endtask

    task automatic test_fill;
        a_out_ready = 1'b1;
        for (int v = 1; v <= 12; v++) push_a(v);
        n_total++;
        if (a_out_valid !== 1'b0) $display("FAIL fill_early_valid got=%b exp=0", a_out_valid);
        else n_pass++;
        push_a(13);
        n_total++;
        if (a_out_valid !== 1'b1) $display("FAIL fill_valid got=%b exp=1", a_out_valid);
        else n_pass++;
        for (int k = 0; k < 13; k++) begin
            n_total++;
            if (a_d[k] !== 32'(k + 1)) $display("FAIL fill_data_%0d got=%0d exp=%0d", k, a_d[k], k + 1);
            else n_pass++;
        end
    endtask

    task automatic test_stream;
        push_a(14);
        n_total++;
        if (a_out_valid !== 1'b1) $display("FAIL stream_valid got=%b exp=1", a_out_valid);
        else n_pass++;
        for (int k = 0; k < 13; k++) begin
            n_total++;
            if (a_d[k] !== 32'(k + 2)) $display("FAIL stream_data_%0d got=%0d exp=%0d", k, a_d[k], k + 2);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure;
        a_out_ready = 1'b0;
        a_in_data   = 32'd15;
        a_in_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_total++;
            if (a_in_ready !== 1'b0) $display("FAIL bp_in_ready c=%0d got=%b exp=0", c, a_in_ready);
            else n_pass++;
            @(posedge clk);
            #1;
            n_total++;
            if (a_out_valid !== 1'b1 || a_d[0] !== 32'd2 || a_d[12] !== 32'd14)
                $display("FAIL bp_hold c=%0d got v=%b d0=%0d d12=%0d exp v=1 d0=2 d12=14",
                         c, a_out_valid, a_d[0], a_d[12]);
            else n_pass++;
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        push_a(15);
        push_a(16);
        n_total++;
        if (a_out_valid !== 1'b1) $display("FAIL bp_resume_valid got=%b exp=1", a_out_valid);
        else n_pass++;
        for (int k = 0; k < 13; k++) begin
            n_total++;
            if (a_d[k] !== 32'(k + 4)) $display("FAIL bp_resume_data_%0d got=%0d exp=%0d", k, a_d[k], k + 4);
            else n_pass++;
        end
    endtask

    task automatic test_flush;
        a_out_ready = 1'b1;
        a_flush = 1'b1;
        @(posedge clk);
        #1;
        a_flush = 1'b0;
        for (int v = 1; v <= 8; v++) push_a(v);
        a_flush    = 1'b1;
        a_in_data  = 32'd99;
        a_in_valid = 1'b1;
        #1;
        n_total++;
        if (a_in_ready !== 1'b0) $display("FAIL flush_in_ready got=%b exp=0", a_in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        n_total++;
        if (a_out_valid !== 1'b0 || a_d[12] !== 32'd0 || a_d[5] !== 32'd0)
            $display("FAIL flush_clear got v=%b d5=%0d d12=%0d exp 0/0/0", a_out_valid, a_d[5], a_d[12]);
        else n_pass++;
        for (int v = 101; v <= 112; v++) begin
            push_a(v);
            n_total++;
            if (a_out_valid !== 1'b0) $display("FAIL flush_refill_valid v=%0d got=1 exp=0", v);
            else n_pass++;
        end
        push_a(113);
        n_total++;
        if (a_out_valid !== 1'b1) $display("FAIL flush_window_valid got=%b exp=1", a_out_valid);
        else n_pass++;
        for (int k = 0; k < 13; k++) begin
            n_total++;
            if (a_d[k] !== 32'(k + 101)) $display("FAIL flush_data_%0d got=%0d exp=%0d", k, a_d[k], k + 101);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_out;
        a_out_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        n_total++;
        if (a_out_valid !== 1'b0) $display("FAIL rst_mid_valid got=%b exp=0", a_out_valid);
        else n_pass++;
        for (int k = 0; k < 13; k++) begin
            n_total++;
            if (a_d[k] !== 32'd0) $display("FAIL rst_mid_data_%0d got=%0d exp=0", k, a_d[k]);
            else n_pass++;
        end
        for (int v = 201; v <= 212; v++) begin
            push_a(v);
            n_total++;
            if (a_out_valid !== 1'b0) $display("FAIL rst_refill_valid v=%0d got=1 exp=0", v);
            else n_pass++;
        end
        push_a(213);
        n_total++;
        if (a_out_valid !== 1'b1 || a_d[0] !== 32'd201 || a_d[12] !== 32'd213)
            $display("FAIL rst_refill_window got v=%b d0=%0d d12=%0d exp v=1 d0=201 d12=213",
                     a_out_valid, a_d[0], a_d[12]);
        else n_pass++;
    endtask

    task automatic test_stride4;
        int windows;
        logic exp_v;
        windows = 0;
        b_out_ready = 1'b1;
        for (int v = 1; v <= 21; v++) begin
            b_in_data  = 32'(v);
            b_in_valid = 1'b1;
            @(posedge clk);
            #1;
            b_in_valid = 1'b0;
            exp_v = (v == 13 || v == 17 || v == 21);
            n_total++;
            if (b_out_valid !== exp_v) $display("FAIL s4_valid v=%0d got=%b exp=%b", v, b_out_valid, exp_v);
            else n_pass++;
            if (b_out_valid === 1'b1) begin
                windows++;
                n_total++;
                if (b_d[12] !== 32'(v) || b_d[0] !== 32'(v - 12))
                    $display("FAIL s4_window v=%0d got d0=%0d d12=%0d exp d0=%0d d12=%0d",
                             v, b_d[0], b_d[12], v - 12, v);
                else n_pass++;
            end
        end
        n_total++;
        if (windows != 3) $display("FAIL s4_window_count got=%0d exp=3", windows);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_data = '0; a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0;
        b_in_data = '0; b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0;
        test_reset();
        test_fill();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_mid_out();
        test_stride4();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
